spi_shifter: RTL

- Hardware SPI byte engine that replaces per-bit software toggling of SCK/MOSI through the ctrl-write path.
- Sits downstream of the ctrl-address decode. A decoded ctrl write delivers a byte and a one-cycle LOAD strobe.
- The block shifts 8 bits out on MOSI and 8 bits in from MISO, then presents the received byte for the Gigatron bus-read mux.
- nSS stays in the ctrl register; this block never touches chip selects.

---
 rtl/spi_shifter_if.sv | 32 +++
 rtl/spi_shifter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/spi_shifter_if.sv
// Byte-level SPI engine handshake: ctrl-side strobe/data plus the serial pins.
// SPI_CPOL_EN adds the cpol select input.
interface spi_shifter_if;
  logic       load;
  logic [7:0] txd;
  logic       miso;
`ifdef SPI_CPOL_EN
  logic       cpol;
`endif
  logic       sck;
  logic       mosi;
  logic [7:0] rxd;
  logic       busy;
  logic       done;
  logic       ovr;

  modport slave (
`ifdef SPI_CPOL_EN
    input  cpol,
`endif
    input  load, txd, miso,
    output sck, mosi, rxd, busy, done, ovr
  );

  modport master (
`ifdef SPI_CPOL_EN
    output cpol,
`endif
    output load, txd, miso,
    input  sck, mosi, rxd, busy, done, ovr
  );
endinterface

// File: rtl/spi_shifter.sv
// SPI byte engine: shifts TXD out on MOSI (MSB first, mode 0) while sampling MISO into RXD.
// Optional macro SPI_CPOL_EN adds a per-transfer CPOL select (mode 3 when CPOL=1).
module spi_shifter #(
  parameter int HALF = 2,
  parameter int DIVW = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  spi_shifter_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(HALF - 1);

  state_t          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            samp_q, samp_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic [7:0]      rxd_q, rxd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic            idle_lvl;

`ifdef SPI_CPOL_EN
  // Idle SCK level latched per transfer so a mid-transfer CPOL change has no effect.
  logic idle_q, idle_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) idle_q <= 1'b0;
    else       idle_q <= idle_d;
  end

  always_comb begin
    idle_d = idle_q;
    if (state_q == S_IDLE && bus.load) idle_d = bus.cpol;
  end

  assign idle_lvl = idle_q;
`else
  assign idle_lvl = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      samp_q   <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      rxd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      samp_q   <= samp_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      rxd_q    <= rxd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    samp_d   = samp_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    rxd_d    = rxd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          shreg_d  = bus.txd;
          mosi_d   = bus.txd[7];
          bitcnt_d = '0;
          div_d    = '0;
          sck_d    = 1'b0;
          ovr_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_LO;
        end
      end

      S_LO: begin
        if (bus.load) ovr_d = 1'b1;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          sck_d   = 1'b1;
          samp_d  = bus.miso;
          state_d = S_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_HI: begin
        if (bus.load) ovr_d = 1'b1;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          shreg_d = {shreg_q[6:0], samp_q};
          mosi_d  = shreg_q[6];
          if (bitcnt_q == 3'd7) begin
            sck_d   = idle_lvl;
            rxd_d   = {shreg_q[6:0], samp_q};
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            sck_d    = 1'b0;
            bitcnt_d = bitcnt_q + 1'b1;
            state_d  = S_LO;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;
  assign bus.rxd  = rxd_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovr  = ovr_q;

endmodule
